// File: rtl/alu_defs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_defs                                                                   |
// | Opcode and compare-code definitions for the ALU request interface.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package alu_defs;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_CMP  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_resp_fifo                                                              |
// | Synchronous response FIFO, async reset, wrap-bit pointers.                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_full;
  logic             w_empty;
  logic             w_rd;
  logic             w_wr;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd    = i_rd_en && !w_empty;
  // A full FIFO may still take a write when the head leaves in the same cycle.
  assign w_wr    = i_wr_en && (!w_full || w_rd);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  // Stale storage is never exposed: the head reads as zero while empty.
  assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_full    = w_full;
  assign o_empty   = w_empty;

endmodule
`default_nettype wire

// File: rtl/alu_resp_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_resp_unit                                                              |
// | Handshaked ALU execution front-end with in-order response FIFO.            |
// | Optional statistics counters: define ALU_RESP_STATS_EN.                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_resp_unit
  import alu_defs::*;
#(
  parameter int DW    = 32,
  parameter int TAGW  = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [DW-1:0]   req_a,
  input  logic [DW-1:0]   req_b,
  input  logic [TAGW-1:0] req_tag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_overflow,
  output logic [1:0]      rsp_cmp,
  output logic [TAGW-1:0] rsp_tag
`ifdef ALU_RESP_STATS_EN
  ,
  output logic [31:0]     stat_ops,
  output logic [31:0]     stat_ovf,
  input  logic            stat_clr
`endif
);

  localparam int C_ENTRY_W = TAGW + 2 + 1 + DW;

  logic [DW:0]          w_sum;
  logic [DW-1:0]        w_data;
  logic                 w_ovf;
  logic [1:0]           w_cmp;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [C_ENTRY_W-1:0] w_head;

  assign w_sum = {1'b0, req_a} + {1'b0, req_b};

  always_comb begin
    w_data = '0;
    w_ovf  = 1'b0;
    w_cmp  = CMP_EQ;
    case (req_op)
      OP_ADD:  begin w_data = w_sum[DW-1:0]; w_ovf = w_sum[DW]; end
      OP_SUB:  begin w_data = req_a - req_b; w_ovf = (req_a < req_b); end
      OP_AND:  w_data = req_a & req_b;
      OP_OR:   w_data = req_a | req_b;
      OP_XNOR: w_data = ~(req_a ^ req_b);
      OP_CMP: begin
        if (req_a < req_b)      w_cmp = CMP_LT;
        else if (req_a > req_b) w_cmp = CMP_GT;
        else                    w_cmp = CMP_EQ;
      end
      OP_SLL:  w_data = {req_a[DW-2:0], 1'b0};
      OP_SRL:  w_data = {1'b0, req_a[DW-1:1]};
      default: ;
    endcase
  end

  assign w_pop     = rsp_valid && rsp_ready;
  assign req_ready = !w_full || w_pop;
  assign w_push    = req_valid && req_ready;
  assign rsp_valid = !w_empty;

  alu_resp_fifo #(
    .WIDTH (C_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .i_rst     (reset),
    .i_wr_en   (w_push),
    .i_wr_data ({req_tag, w_cmp, w_ovf, w_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign {rsp_tag, rsp_cmp, rsp_overflow, rsp_data} = w_head;

`ifdef ALU_RESP_STATS_EN
  logic [31:0] r_stat_ops;
  logic [31:0] r_stat_ovf;

  // Saturating counters; a clear overrides any increment in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_ops <= '0;
      r_stat_ovf <= '0;
    end else if (stat_clr) begin
      r_stat_ops <= '0;
      r_stat_ovf <= '0;
    end else if (w_push) begin
      if (r_stat_ops != '1)          r_stat_ops <= r_stat_ops + 32'd1;
      if (w_ovf && r_stat_ovf != '1) r_stat_ovf <= r_stat_ovf + 32'd1;
    end
  end

  assign stat_ops = r_stat_ops;
  assign stat_ovf = r_stat_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_resp_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_resp_unit                                                           |
// | Directed table-driven bench for alu_resp_unit (ALU_RESP_STATS_EN aware).   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alu_resp_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_overflow;
  logic [1:0]  rsp_cmp;
  logic [3:0]  rsp_tag;
`ifdef ALU_RESP_STATS_EN
  logic [31:0] stat_ops;
  logic [31:0] stat_ovf;
  logic        stat_clr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_resp_unit #(.DW(32), .TAGW(4), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tag      (req_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_overflow (rsp_overflow),
    .rsp_cmp      (rsp_cmp),
    .rsp_tag      (rsp_tag)
`ifdef ALU_RESP_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_ovf     (stat_ovf),
    .stat_clr     (stat_clr)
`endif
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] d;
    logic        ovf;
    logic [1:0]  cmp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
  endtask

  // One request into an empty unit with rsp_ready high: response the next cycle.
  task automatic apply_vec(input vec_t v, input int idx);
    drive(v.op, v.a, v.b, v.tag);
    check($sformatf("vec%0d req_ready", idx), req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check($sformatf("vec%0d rsp_valid", idx), rsp_valid, 1);
    check($sformatf("vec%0d data", idx), rsp_data, v.d);
    check($sformatf("vec%0d ovf", idx), rsp_overflow, v.ovf);
    check($sformatf("vec%0d cmp", idx), rsp_cmp, v.cmp);
    check($sformatf("vec%0d tag", idx), rsp_tag, v.tag);
    @(posedge clk); #1;
    check($sformatf("vec%0d drained", idx), rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b0001, 32'd10,         32'd10,         4'h1, 32'd20,         1'b0, 2'b00};
    vecs[1]  = '{4'b0001, 32'hFFFF_FFFF,  32'd1,          4'h2, 32'd0,          1'b1, 2'b00};
    vecs[2]  = '{4'b0010, 32'd20,         32'd30,         4'h3, 32'hFFFF_FFF6,  1'b1, 2'b00};
    vecs[3]  = '{4'b0110, 32'd10,         32'd20,         4'h4, 32'd0,          1'b0, 2'b01};
    vecs[4]  = '{4'b0110, 32'd20,         32'd5,          4'h5, 32'd0,          1'b0, 2'b10};
    vecs[5]  = '{4'b0110, 32'd2,          32'd2,          4'h6, 32'd0,          1'b0, 2'b00};
    vecs[6]  = '{4'b0101, 32'h0000_FFFF,  32'h0000_FFFF,  4'h7, 32'hFFFF_FFFF,  1'b0, 2'b00};
    vecs[7]  = '{4'b0111, 32'hFFFF_FFFF,  32'd0,          4'h8, 32'hFFFF_FFFE,  1'b0, 2'b00};
    vecs[8]  = '{4'b1000, 32'hF0FA_F0FA,  32'd0,          4'h9, 32'h787D_787D,  1'b0, 2'b00};
    vecs[9]  = '{4'b1111, 32'd123,        32'd456,        4'hA, 32'd0,          1'b0, 2'b00};
    vecs[10] = '{4'b0011, 32'hF0F0_1234,  32'h0FF0_FFFF,  4'hB, 32'h00F0_1234,  1'b0, 2'b00};
    vecs[11] = '{4'b0100, 32'hF0F0_0000,  32'h0F0F_0001,  4'hC, 32'hFFFF_0001,  1'b0, 2'b00};
    vecs[12] = '{4'b0010, 32'd5,          32'd5,          4'hD, 32'd0,          1'b0, 2'b00};
    vecs[13] = '{4'b0001, 32'h8000_0000,  32'h8000_0000,  4'hE, 32'd0,          1'b1, 2'b00};
    vecs[14] = '{4'b0000, 32'd7,          32'd9,          4'hF, 32'd0,          1'b0, 2'b00};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
`ifdef ALU_RESP_STATS_EN
    stat_clr  = 1'b0;
`endif
    #1;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset rsp_overflow", rsp_overflow, 0);
    check("reset rsp_cmp", rsp_cmp, 0);
    check("reset rsp_tag", rsp_tag, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("post-reset req_ready", req_ready, 1);

    for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);

    // Back-pressure: four fill the FIFO, the fifth waits for a pop.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, 32'(i), 32'd100, 4'(i));
      check($sformatf("bp ready %0d", i), req_ready, 1);
      @(posedge clk); #1;
    end
    drive(4'b0001, 32'd4, 32'd100, 4'd4);
    check("bp full ready", req_ready, 0);
    check("bp head valid", rsp_valid, 1);
    check("bp head data", rsp_data, 100);
    @(posedge clk); #1;
    check("bp stall ready", req_ready, 0);
    check("bp head stable data", rsp_data, 100);
    check("bp head stable tag", rsp_tag, 0);
    rsp_ready = 1'b1;
    #1;
    check("bp push+pop ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      check($sformatf("bp order valid %0d", k), rsp_valid, 1);
      check($sformatf("bp order data %0d", k), rsp_data, 32'(100 + k));
      check($sformatf("bp order tag %0d", k), rsp_tag, 4'(k));
      @(posedge clk); #1;
    end
    check("bp drained", rsp_valid, 0);

    // Asynchronous reset with three queued responses.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 32'(i + 1), 32'd0, 4'(i + 5));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("pre-areset valid", rsp_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("areset immediate valid", rsp_valid, 0);
    check("areset immediate data", rsp_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("areset queue empty", rsp_valid, 0);
    check("areset req_ready", req_ready, 1);
    rsp_ready = 1'b1;

`ifdef ALU_RESP_STATS_EN
    check("stats reset ops", stat_ops, 0);
    check("stats reset ovf", stat_ovf, 0);
    drive(4'b0001, 32'd1, 32'd1, 4'd1);
    @(posedge clk); #1;
    drive(4'b0001, 32'hFFFF_FFFF, 32'd1, 4'd2);
    @(posedge clk); #1;
    drive(4'b0001, 32'd2, 32'd3, 4'd3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("stats ops", stat_ops, 3);
    check("stats ovf", stat_ovf, 1);
    drive(4'b0001, 32'hFFFF_FFFF, 32'd2, 4'd4);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    stat_clr  = 1'b0;
    check("stats clr ops", stat_ops, 0);
    check("stats clr ovf", stat_ovf, 0);
    repeat (2) @(posedge clk);
    #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
